// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit path (TX FIFO input) among NUM_SRC byte sources.
//   Round-robin arbitration; a grant is held for a whole line so that text
//   from different sources never interleaves on the wire. A grant ends after
//   the EOP_CHAR byte transfers or after MAX_BURST bytes, whichever is first.
//
//   Optional feature (macro TX_ARB_TIMEOUT_EN): a granted source that keeps
//   its valid deasserted for IDLE_TIMEOUT cycles loses the grant.
//
// Ports (all handshakes active-low, transfer = valid_n==0 && ready_n==0 at clk rise)
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   src_valid_n  per-source byte valid
//   src_data     per-source byte, source i at [8*i+7:8*i]
//   src_ready_n  per-source ready
//   out_valid_n  byte valid toward TX FIFO
//   out_data     byte toward TX FIFO (8'h00 while no grant)
//   out_ready_n  TX FIFO not full
//   grant_valid  1 while a source holds the grant
//   grant_idx    index of the granted source (meaningful when grant_valid)

module uart_tx_arbiter #(
    parameter int unsigned NUM_SRC      = 2,
    parameter logic [7:0]  EOP_CHAR     = 8'h0A,
    parameter int unsigned MAX_BURST    = 80,
    parameter int unsigned IDLE_TIMEOUT = 16,
    localparam int unsigned IdxW        = $clog2(NUM_SRC),
    localparam int unsigned CntW        = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid_n,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready_n,
    output logic                 out_valid_n,
    output logic [7:0]           out_data,
    input  logic                 out_ready_n,
    output logic                 grant_valid,
    output logic [IdxW-1:0]      grant_idx
);

    // Elaboration-time parameter sanity checks.
    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("uart_tx_arbiter: NUM_SRC must be in 2..8");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("uart_tx_arbiter: MAX_BURST must be >= 1");
    end
    if (IDLE_TIMEOUT < 1) begin : g_bad_idle_timeout
        $error("uart_tx_arbiter: IDLE_TIMEOUT must be >= 1");
    end

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] grant_idx_q, grant_idx_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

    // Granted-channel view.
    logic            g_valid_n;
    logic [7:0]      g_data;
    logic            xfer;
    logic            line_end;
    logic            timeout_fire;
    logic [IdxW-1:0] rr_after_grant;

    // Round-robin pick.
    logic            pick_found;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] cand_idx;
    int unsigned     cand;

    assign g_valid_n = src_valid_n[grant_idx_q];
    assign g_data    = src_data[8*int'(grant_idx_q) +: 8];
    assign xfer      = (state_q == StLock) && !g_valid_n && !out_ready_n;

    // Either condition ends the grant; both together still release only once.
    assign line_end  = (g_data == EOP_CHAR) ||
                       ((burst_cnt_q + CntW'(1)) == CntW'(MAX_BURST));

    // Pointer moves just past the source that held the grant, wrapping to 0.
    assign rr_after_grant = (grant_idx_q == IdxW'(NUM_SRC - 1)) ? '0 :
                            grant_idx_q + IdxW'(1);

    // Scan rr_ptr, rr_ptr+1, ... modulo NUM_SRC; first active requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = IdxW'(cand);
            if (!pick_found && !src_valid_n[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    // Only cycles where the granted source itself has nothing to send count;
    // a FIFO stall with a byte pending is never treated as idleness.
    assign timeout_fire = (state_q == StLock) && g_valid_n &&
                          (idle_cnt_q == IdleW'(IDLE_TIMEOUT - 1));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != StLock) begin
            idle_cnt_d = '0;
        end else if (xfer || timeout_fire) begin
            idle_cnt_d = '0;
        end else if (g_valid_n) begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // Next-state and outputs.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        out_valid_n = 1'b1;
        out_data    = 8'h00;
        src_ready_n = '1;
        grant_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d     = StLock;
                    grant_idx_d = pick_idx;
                    burst_cnt_d = '0;
                end
            end

            StLock: begin
                // Pure combinational forward of the granted channel.
                grant_valid              = 1'b1;
                out_valid_n              = g_valid_n;
                out_data                 = g_data;
                src_ready_n[grant_idx_q] = out_ready_n;

                if (xfer) begin
                    if (line_end) begin
                        state_d     = StIdle;
                        rr_ptr_d    = rr_after_grant;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CntW'(1);
                    end
                end else if (timeout_fire) begin
                    state_d     = StIdle;
                    rr_ptr_d    = rr_after_grant;
                    burst_cnt_d = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign grant_idx = grant_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed, table-driven bench for uart_tx_arbiter (NUM_SRC=2, MAX_BURST=4,
//   IDLE_TIMEOUT=16). Each table row is one clock cycle: inputs are applied
//   just after a rising edge, outputs are checked mid-cycle. A hand-written
//   sequence at the end covers the idle-timeout behaviour.

module tb_uart_tx_arbiter;

    localparam logic [7:0] NL = 8'h0A;

    logic        clk;
    logic        rst;
    logic [1:0]  src_valid_n;
    logic [15:0] src_data;
    logic [1:0]  src_ready_n;
    logic        out_valid_n;
    logic [7:0]  out_data;
    logic        out_ready_n;
    logic        grant_valid;
    logic [0:0]  grant_idx;

    int n_vec;
    int n_err;

    uart_tx_arbiter #(
        .NUM_SRC      (2),
        .EOP_CHAR     (8'h0A),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid_n  (src_valid_n),
        .src_data     (src_data),
        .src_ready_n  (src_ready_n),
        .out_valid_n  (out_valid_n),
        .out_data     (out_data),
        .out_ready_n  (out_ready_n),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [1:0] vn;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_sr;
        logic       e_gv;
        logic       e_gi;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] vn, input logic [7:0] d0,
                       input logic [7:0] d1, input logic ordy, input logic e_ov,
                       input logic [7:0] e_od, input logic [1:0] e_sr,
                       input logic e_gv, input logic e_gi);
        vec_t v;
        v.rst = r;   v.vn = vn;     v.d0 = d0;     v.d1 = d1;     v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_sr = e_sr; v.e_gv = e_gv; v.e_gi = e_gi;
        vecs.push_back(v);
    endtask

    int first_drop;
    int first_g1;

    initial begin
        n_vec = 0;
        n_err = 0;

        //   rst vn     d0   d1   ordy | ov   od     sr     gv   gi
        // Reset with src0 requesting, then 1-cycle arbitration latency.
        add(1, 2'b10, "a", 0,   0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b10, "a", 0,   0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b10, "a", 0,   0,     0, "a",   2'b10, 1, 0);
        // Line lock: src1 waits through src0's "ab\n".
        add(0, 2'b00, "b", "x", 0,     0, "b",   2'b10, 1, 0);
        add(0, 2'b00, NL,  "x", 0,     0, NL,    2'b10, 1, 0);
        add(0, 2'b01, 0,   "x", 0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b01, 0,   "x", 0,     0, "x",   2'b01, 1, 1);
        add(0, 2'b01, 0,   NL,  0,     0, NL,    2'b01, 1, 1);
        // Round robin with both always requesting, pointer wraps 1 -> 0.
        add(0, 2'b00, "1", "2", 0,     1, 8'h00, 2'b11, 0, 1);
        add(0, 2'b00, "1", "2", 0,     0, "1",   2'b10, 1, 0);
        add(0, 2'b00, NL,  "2", 0,     0, NL,    2'b10, 1, 0);
        add(0, 2'b00, "1", "2", 0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b00, "1", "2", 0,     0, "2",   2'b01, 1, 1);
        add(0, 2'b00, "1", NL,  0,     0, NL,    2'b01, 1, 1);
        add(0, 2'b00, "1", "2", 0,     1, 8'h00, 2'b11, 0, 1);
        add(0, 2'b00, "1", "2", 0,     0, "1",   2'b10, 1, 0);
        add(0, 2'b00, NL,  "2", 0,     0, NL,    2'b10, 1, 0);
        // Burst cap of 4: a,b,c,d then src1's line, then src0 resumes with e.
        add(0, 2'b10, "a", 0,   0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b00, "a", "y", 0,     0, "a",   2'b10, 1, 0);
        add(0, 2'b00, "b", "y", 0,     0, "b",   2'b10, 1, 0);
        add(0, 2'b00, "c", "y", 0,     0, "c",   2'b10, 1, 0);
        add(0, 2'b00, "d", "y", 0,     0, "d",   2'b10, 1, 0);
        add(0, 2'b00, "e", "y", 0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b00, "e", "y", 0,     0, "y",   2'b01, 1, 1);
        add(0, 2'b00, "e", NL,  0,     0, NL,    2'b01, 1, 1);
        add(0, 2'b00, "e", "z", 0,     1, 8'h00, 2'b11, 0, 1);
        add(0, 2'b00, "e", "z", 0,     0, "e",   2'b10, 1, 0);
        // Backpressure for 5 cycles: nothing moves or counts.
        for (int i = 0; i < 5; i++) begin
            add(0, 2'b00, "f", "z", 1, 0, "f",   2'b11, 1, 0);
        end
        add(0, 2'b00, "f", "z", 0,     0, "f",   2'b10, 1, 0);
        add(0, 2'b00, "g", "z", 0,     0, "g",   2'b10, 1, 0);
        // 4th byte of this grant: cap releases only if the stall was not counted.
        add(0, 2'b00, "h", "z", 0,     0, "h",   2'b10, 1, 0);
        add(0, 2'b00, "i", "z", 0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b00, "i", NL,  0,     0, NL,    2'b01, 1, 1);
        // EOP coincides with the cap on the 4th byte: one release only.
        add(0, 2'b10, "a", 0,   0,     1, 8'h00, 2'b11, 0, 1);
        add(0, 2'b10, "a", 0,   0,     0, "a",   2'b10, 1, 0);
        add(0, 2'b10, "b", 0,   0,     0, "b",   2'b10, 1, 0);
        add(0, 2'b10, "c", 0,   0,     0, "c",   2'b10, 1, 0);
        add(0, 2'b10, NL,  0,   0,     0, NL,    2'b10, 1, 0);
        add(0, 2'b10, "m", 0,   0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b10, "m", 0,   0,     0, "m",   2'b10, 1, 0);
        // Granted source pauses mid-line: grant held, src1 still locked out.
        add(0, 2'b01, "q", "w", 0,     1, "q",   2'b10, 1, 0);
        add(0, 2'b01, "q", "w", 0,     1, "q",   2'b10, 1, 0);
        add(0, 2'b00, NL,  "w", 0,     0, NL,    2'b10, 1, 0);
        // No requesters: stays idle.
        add(0, 2'b11, 0,   0,   0,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b11, 0,   0,   0,     1, 8'h00, 2'b11, 0, 0);
        // Reset mid-line while stalled: byte stays at the source.
        add(0, 2'b10, "r", 0,   0,     1, 8'h00, 2'b11, 0, 0);
        add(1, 2'b10, "r", 0,   1,     0, "r",   2'b11, 1, 0);
        add(0, 2'b10, "r", 0,   1,     1, 8'h00, 2'b11, 0, 0);
        add(0, 2'b10, "r", 0,   1,     0, "r",   2'b11, 1, 0);
        add(0, 2'b10, "r", 0,   0,     0, "r",   2'b10, 1, 0);

        // Bring the DUT to a known state before the first row.
        rst         = 1'b1;
        src_valid_n = 2'b11;
        src_data    = 16'h0000;
        out_ready_n = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            src_valid_n = vecs[i].vn;
            src_data    = {vecs[i].d1, vecs[i].d0};
            out_ready_n = vecs[i].ordy;
            #4;
            n_vec++;
            if (out_valid_n !== vecs[i].e_ov || out_data !== vecs[i].e_od ||
                src_ready_n !== vecs[i].e_sr || grant_valid !== vecs[i].e_gv ||
                grant_idx !== vecs[i].e_gi) begin
                n_err++;
                $display("FAIL vec %0d: got ov=%b od=%h sr=%b gv=%b gi=%b, want ov=%b od=%h sr=%b gv=%b gi=%b",
                         i, out_valid_n, out_data, src_ready_n, grant_valid, grant_idx,
                         vecs[i].e_ov, vecs[i].e_od, vecs[i].e_sr, vecs[i].e_gv,
                         vecs[i].e_gi);
            end
            @(posedge clk);
            #1;
        end

        // Idle timeout: src0 sends "a" then goes quiet while src1 keeps requesting.
        rst         = 1'b1;
        src_valid_n = 2'b11;
        out_ready_n = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        src_valid_n = 2'b00;
        src_data    = {8'("x"), 8'("a")};
        @(posedge clk);
        #1;
        #4;
        n_vec++;
        if (grant_valid !== 1'b1 || grant_idx !== 1'b0 || out_data !== "a") begin
            n_err++;
            $display("FAIL timeout_setup: got gv=%b gi=%b od=%h, want gv=1 gi=0 od=61",
                     grant_valid, grant_idx, out_data);
        end
        @(posedge clk);
        #1;
        src_valid_n = 2'b01;
        first_drop  = -1;
        first_g1    = -1;
        for (int k = 0; k < 40; k++) begin
            #4;
            if (first_drop < 0 && grant_valid !== 1'b1) first_drop = k;
            if (first_g1 < 0 && grant_valid === 1'b1 && grant_idx === 1'b1) first_g1 = k;
            @(posedge clk);
            #1;
        end
`ifdef TX_ARB_TIMEOUT_EN
        n_vec++;
        if (first_drop != 16) begin
            n_err++;
            $display("FAIL timeout_release: got cycle %0d, want 16", first_drop);
        end
        n_vec++;
        if (first_g1 != 17) begin
            n_err++;
            $display("FAIL timeout_src1_grant: got cycle %0d, want 17", first_g1);
        end
`else
        n_vec++;
        if (first_drop != -1) begin
            n_err++;
            $display("FAIL hold_no_timeout: grant dropped at cycle %0d, want never", first_drop);
        end
        n_vec++;
        if (first_g1 != -1) begin
            n_err++;
            $display("FAIL src1_locked_out: src1 granted at cycle %0d, want never", first_g1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
